rggen_bus_initiator: RTL and testbench
======================================

// Module: rggen_bus_initiator
// PURPOSE
//  Single-outstanding initiator for rggen_bus_if: the requesting end of the bus that the adapters terminate.
//  - Takes register-access commands on a valid/ready command port.
//  - Drives them onto rggen_bus_if, holding each request stable until bus ready.
//  - Returns status and read data on a valid/ready response port.
//  - Used by on-chip sequencers, debug bridges and the verification harness to reach rggen register blocks.
// PARAMETERS
//  ADDRESS_WIDTH   8   bus address width
//  BUS_WIDTH       32  data width; strobe width is BUS_WIDTH/8
//  TIMEOUT_CYCLES  0   wait cycles before o_timeout asserts; 0 disables the counter
// PORTS
//  i_clk            in   1              clock; single clock domain
//  i_rst_n          in   1              reset, synchronous, active-low
//  i_cmd_valid      in   1              command valid
//  o_cmd_ready      out  1              command accepted when valid&&ready
//  i_cmd_access     in   rggen_access   READ / WRITE / POSTED_WRITE
//  i_cmd_address    in   ADDRESS_WIDTH  byte address, passed unchanged
//  i_cmd_write_data in   BUS_WIDTH      write data
//  i_cmd_strobe     in   BUS_WIDTH/8    byte strobe
//  o_rsp_valid      out  1              response valid
//  i_rsp_ready      in   1              response consumed when valid&&ready
//  o_rsp_status     out  rggen_status   captured bus status
//  o_rsp_read_data  out  BUS_WIDTH      captured read data; 0 for write accesses
//  o_timeout        out  1              current request has waited >= TIMEOUT_CYCLES
//  bus_if           rggen_bus_if.master outgoing request/response bus
// BEHAVIOUR
//  - States: IDLE, REQUEST, RESPONSE. All state transitions occur on the rising edge of i_clk.
//  - Reset (i_rst_n low at an edge):
//    - state=IDLE.
//    - bus_if.valid=0; o_rsp_valid=0; o_timeout=0.
//    - Captured command, status and read-data registers cleared to '0.
//    - Reset mid-transfer drops bus valid next edge; no response is produced.
//  - o_cmd_ready = (state==IDLE) || (state==RESPONSE && i_rsp_ready).
//    - This is a combinational rsp_ready->cmd_ready path. It is required for back-to-back throughput.
//  - Command accept: fields are registered and state goes to REQUEST.
//    - bus_if.valid=1 from the next cycle, driven from registers only.
//  - REQUEST: access, address, write_data and strobe stay constant until bus_if.ready is sampled high.
//    - Valid is never withdrawn before ready, including on timeout.
//  - On bus_if.ready high in REQUEST:
//    - Capture status and read_data; read_data is forced to 0 unless access==READ.
//    - State goes to RESPONSE; bus_if.valid=0 next cycle.
//  - Ready arriving in the same cycle valid first rises is legal. Minimum latency is 2 cycles from command accept to o_rsp_valid.
//  - RESPONSE: o_rsp_valid=1 with stable outputs until i_rsp_ready.
//    - Then IDLE, or REQUEST if a new command is accepted in the same cycle.
//  - bus_if.ready outside REQUEST is ignored.
//  - Timeout counter:
//    - Cleared on command accept; increments each REQUEST cycle with ready low; saturates.
//    - o_timeout=1 while count>=TIMEOUT_CYCLES in REQUEST; cleared when leaving REQUEST.
//    - Constant 0 when TIMEOUT_CYCLES==0.
//    - Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1.
// STRUCTURE
//  - rggen_access and rggen_status come from rggen_rtl_pkg.
//  - State enum stays local: only this block uses it.
//  - No sub-module; the timeout counter is inline.
//  - SVA under RGGEN_ENABLE_SVA:
//    - request stable until ready;
//    - o_rsp_valid stable until i_rsp_ready;
//    - at most one outstanding request.
// TESTING
//  1. Read with ready on the first bus cycle:
//     - Stimulus: READ @0x10; slave returns 0xDEADBEEF, OKAY in the first valid cycle.
//     - Expect: rsp_valid 2 cycles after command accept with data 0xDEADBEEF, OKAY.
//  2. Write with a stalling slave:
//     - Stimulus: WRITE @0x24, data 0x12345678, strobe 4'b0011; slave waits 5 cycles.
//     - Expect: address, data and strobe unchanged all 5 cycles; response read_data=0.
//  3. Back-to-back commands:
//     - Stimulus: two READs where cmd 2 is presented while rsp 1 is valid and i_rsp_ready=1.
//     - Expect: cmd 2 accepted in that same cycle; no idle bus cycle inserted.
//  4. Response backpressure:
//     - Stimulus: i_rsp_ready low for 4 cycles; slave returns SLAVE_ERROR.
//     - Expect: rsp outputs stable for the 4 cycles; o_cmd_ready=0 throughout.
//  5. Timeout:
//     - Stimulus: TIMEOUT_CYCLES=3, slave never ready.
//     - Expect: o_timeout rises after 3 wait cycles; bus_if.valid stays 1.
//     - Then ready arrives: o_timeout clears and the response is delivered.
//  6. Reset mid-REQUEST:
//     - Stimulus: assert i_rst_n=0 for 1 cycle while a request is stalled.
//     - Expect: bus_if.valid=0 and o_rsp_valid=0 after the edge; state returns to IDLE.

Source files
------------

// File: rtl/rggen_rtl_pkg.sv
// rggen_rtl_pkg: access and status encodings shared by rggen bus initiators, adapters and register blocks.
package rggen_rtl_pkg;
   typedef enum logic [1:0] {
      RGGEN_POSTED_WRITE = 2'b01,
      RGGEN_READ         = 2'b10,
      RGGEN_WRITE        = 2'b11
   } rggen_access;
   typedef enum logic [1:0] {
      RGGEN_OKAY         = 2'b00,
      RGGEN_EXOKAY       = 2'b01,
      RGGEN_SLAVE_ERROR  = 2'b10,
      RGGEN_DECODE_ERROR = 2'b11
   } rggen_status;
endpackage

// File: rtl/rggen_bus_if.sv
// rggen_bus_if: request/response register bus between an initiator and rggen register blocks.
interface rggen_bus_if #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int BUS_WIDTH     = 32
)();
   logic                          valid;
   rggen_rtl_pkg::rggen_access    access;
   logic [ADDRESS_WIDTH-1:0]      address;
   logic [BUS_WIDTH-1:0]          write_data;
   logic [BUS_WIDTH/8-1:0]        strobe;
   logic                          ready;
   rggen_rtl_pkg::rggen_status    status;
   logic [BUS_WIDTH-1:0]          read_data;
   modport master (
      output valid, access, address, write_data, strobe,
      input  ready, status, read_data
   );
   modport slave (
      input  valid, access, address, write_data, strobe,
      output ready, status, read_data
   );
endinterface

// File: rtl/rggen_bus_initiator.sv
// rggen_bus_initiator: single-outstanding initiator turning valid/ready commands into rggen_bus_if
// transfers and returning the captured status/read data on a valid/ready response port.
module rggen_bus_initiator
   import rggen_rtl_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = 8,
   parameter int BUS_WIDTH      = 32,
   parameter int TIMEOUT_CYCLES = 0
)(
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_cmd_valid,
   output logic                     o_cmd_ready,
   input  rggen_access              i_cmd_access,
   input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
   input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
   input  logic [BUS_WIDTH/8-1:0]   i_cmd_strobe,
   output logic                     o_rsp_valid,
   input  logic                     i_rsp_ready,
   output rggen_status              o_rsp_status,
   output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
   output logic                     o_timeout,
   rggen_bus_if.master              bus_if
);
   localparam logic [1:0] IDLE = 2'd0, REQUEST = 2'd1, RESPONSE = 2'd2;
   logic [1:0]               state;
   logic [1:0]               access;
   logic [ADDRESS_WIDTH-1:0] address;
   logic [BUS_WIDTH-1:0]     write_data;
   logic [BUS_WIDTH/8-1:0]   strobe;
   logic [1:0]               status;
   logic                     cmd_ack;
   logic                     bus_ack;
   // cmd_ready sees rsp_ready combinationally so a new command can follow a consumed response with no gap
   assign o_cmd_ready = (state == IDLE) || ((state == RESPONSE) && i_rsp_ready);
   assign cmd_ack     = i_cmd_valid && o_cmd_ready;
   assign bus_ack     = (state == REQUEST) && bus_if.ready;
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state           <= IDLE;
         access          <= '0;
         address         <= '0;
         write_data      <= '0;
         strobe          <= '0;
         status          <= '0;
         o_rsp_read_data <= '0;
      end else begin
         if (cmd_ack) begin
            state      <= REQUEST;
            access     <= i_cmd_access;
            address    <= i_cmd_address;
            write_data <= i_cmd_write_data;
            strobe     <= i_cmd_strobe;
         end else if (bus_ack) begin
            state <= RESPONSE;
         end else if ((state == RESPONSE) && i_rsp_ready) begin
            state <= IDLE;
         end
         if (bus_ack) begin
            status          <= bus_if.status;
            o_rsp_read_data <= (access == RGGEN_READ) ? bus_if.read_data : '0;
         end
      end
   end
   assign bus_if.valid      = state == REQUEST;
   assign bus_if.access     = rggen_access'(access);
   assign bus_if.address    = address;
   assign bus_if.write_data = write_data;
   assign bus_if.strobe     = strobe;
   assign o_rsp_valid       = state == RESPONSE;
   assign o_rsp_status      = rggen_status'(status);
   if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      assign o_timeout = 1'b0;
   end else begin : g_timeout
      localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
      logic [CW-1:0] count;
      always_ff @(posedge i_clk) begin
         if (!i_rst_n || cmd_ack)
            count <= '0;
         else if ((state == REQUEST) && !bus_if.ready && (count != LIMIT))
            count <= count + 1'b1;
      end
      assign o_timeout = (state == REQUEST) && (count >= LIMIT);
   end
`ifdef RGGEN_ENABLE_SVA
   ap_request_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      bus_if.valid && !bus_if.ready |=> bus_if.valid &&
      $stable({bus_if.access, bus_if.address, bus_if.write_data, bus_if.strobe}));
   ap_response_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      o_rsp_valid && !i_rsp_ready |=> o_rsp_valid && $stable({o_rsp_status, o_rsp_read_data}));
   ap_single_outstanding: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(bus_if.valid && o_rsp_valid));
`endif
endmodule

// File: tb/tb_rggen_bus_initiator.sv
// tb_rggen_bus_initiator: directed bench with a transaction-level model checked every cycle
// and hand-computed expectations for the key scenarios.
module tb_rggen_bus_initiator;
   import rggen_rtl_pkg::*;
   localparam int TO = 3;
   logic        clk = 0;
   logic        rst_n = 0;
   logic        cmd_valid = 0;
   logic        cmd_ready;
   rggen_access cmd_access = RGGEN_READ;
   logic [7:0]  cmd_address = '0;
   logic [31:0] cmd_write_data = '0;
   logic [3:0]  cmd_strobe = '0;
   logic        rsp_valid;
   logic        rsp_ready = 0;
   rggen_status rsp_status;
   logic [31:0] rsp_read_data;
   logic        timeout;
   int          checks = 0, errors = 0, cyc = 0;
   bit          model_on = 0;
   int          slave_wait = 0, slave_cnt = 0;
   rggen_status slave_status = RGGEN_OKAY;
   logic [31:0] slave_data = '0;
   rggen_bus_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) bus_if ();
   rggen_bus_initiator #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_cmd_valid      (cmd_valid),
      .o_cmd_ready      (cmd_ready),
      .i_cmd_access     (cmd_access),
      .i_cmd_address    (cmd_address),
      .i_cmd_write_data (cmd_write_data),
      .i_cmd_strobe     (cmd_strobe),
      .o_rsp_valid      (rsp_valid),
      .i_rsp_ready      (rsp_ready),
      .o_rsp_status     (rsp_status),
      .o_rsp_read_data  (rsp_read_data),
      .o_timeout        (timeout),
      .bus_if           (bus_if)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   // slave: raises ready once a request has been valid for slave_wait cycles
   always @(posedge clk) begin
      #1;
      if (bus_if.valid) begin
         bus_if.ready = slave_cnt >= slave_wait;
         slave_cnt++;
      end else begin
         bus_if.ready = 1'b0;
         slave_cnt = 0;
      end
      bus_if.status    = slave_status;
      bus_if.read_data = slave_data;
   end
   // model: one command in flight on the bus, at most one response held for the consumer
   bit          m_inflight = 0, m_rsp = 0;
   logic [1:0]  m_acc = '0, m_status = '0;
   logic [7:0]  m_addr = '0;
   logic [31:0] m_wdata = '0, m_rdata = '0;
   logic [3:0]  m_strb = '0;
   int          m_wait = 0;
   always @(negedge clk) begin
      bit exp_ready, done, took;
      exp_ready = !m_inflight && (!m_rsp || rsp_ready);
      if (model_on) begin
         check("cmd_ready", cmd_ready, exp_ready);
         check("bus_valid", bus_if.valid, m_inflight);
         check("rsp_valid", rsp_valid, m_rsp);
         check("timeout", timeout, m_inflight && (m_wait >= TO));
         if (m_inflight) begin
            check("bus_access", bus_if.access, m_acc);
            check("bus_address", bus_if.address, m_addr);
            check("bus_write_data", bus_if.write_data, m_wdata);
            check("bus_strobe", bus_if.strobe, m_strb);
         end
         if (m_rsp) begin
            check("rsp_status", rsp_status, m_status);
            check("rsp_read_data", rsp_read_data, m_rdata);
         end
      end
      if (!rst_n) begin
         m_inflight = 0;
         m_rsp      = 0;
         m_wait     = 0;
      end else begin
         done = m_inflight && (bus_if.ready === 1'b1);
         took = cmd_valid && exp_ready;
         if (m_rsp && rsp_ready) m_rsp = 0;
         if (done) begin
            m_inflight = 0;
            m_rsp      = 1;
            m_status   = bus_if.status;
            m_rdata    = (m_acc == RGGEN_READ) ? bus_if.read_data : 32'h0;
         end else if (m_inflight) begin
            m_wait++;
         end
         if (took) begin
            m_inflight = 1;
            m_wait     = 0;
            m_acc      = cmd_access;
            m_addr     = cmd_address;
            m_wdata    = cmd_write_data;
            m_strb     = cmd_strobe;
         end
      end
   end
   task automatic send(input rggen_access a, input logic [7:0] ad, input logic [31:0] wd,
                       input logic [3:0] st, output int c);
      int n = 0;
      bit ok = 0;
      cmd_valid = 1; cmd_access = a; cmd_address = ad; cmd_write_data = wd; cmd_strobe = st;
      do begin
         @(negedge clk);
         ok = cmd_ready;
         c = cyc;
         @(posedge clk); #1;
         n++;
      end while (!ok && n < 100);
      if (!ok) begin
         checks++; errors++;
         $display("FAIL cmd_accept: no handshake within 100 cycles");
      end
      cmd_valid = 0;
   endtask
   task automatic wait_rsp(output int c);
      int n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!rsp_valid) begin
         checks++; errors++;
         $display("FAIL rsp_wait: no response within 200 cycles");
      end
      c = cyc;
   endtask
   task automatic consume;
      @(posedge clk); #1 rsp_ready = 1;
      @(posedge clk); #1 rsp_ready = 0;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int a1, a2, rc;
      repeat (2) @(posedge clk);
      #1 model_on = 1;
      @(negedge clk);
      check("reset_bus_valid", bus_if.valid, 1'b0);
      check("reset_rsp_valid", rsp_valid, 1'b0);
      check("reset_timeout", timeout, 1'b0);
      check("reset_cmd_ready", cmd_ready, 1'b1);
      @(posedge clk); #1 rst_n = 1;
      // read answered in the first valid cycle
      slave_wait = 0; slave_status = RGGEN_OKAY; slave_data = 32'hDEAD_BEEF;
      send(RGGEN_READ, 8'h10, 32'h0, 4'hF, a1);
      wait_rsp(rc);
      check("t1_latency", rc - a1, 2);
      check("t1_data", rsp_read_data, 32'hDEAD_BEEF);
      check("t1_status", rsp_status, RGGEN_OKAY);
      consume;
      // write against a slave that stalls five cycles
      slave_wait = 5; slave_data = 32'hCAFE_F00D;
      send(RGGEN_WRITE, 8'h24, 32'h1234_5678, 4'b0011, a1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t2_valid", bus_if.valid, 1'b1);
         check("t2_address", bus_if.address, 8'h24);
         check("t2_data", bus_if.write_data, 32'h1234_5678);
         check("t2_strobe", bus_if.strobe, 4'b0011);
      end
      wait_rsp(rc);
      check("t2_read_data", rsp_read_data, 32'h0);
      check("t2_status", rsp_status, RGGEN_OKAY);
      consume;
      // back-to-back reads with the consumer always ready
      rsp_ready = 1; slave_wait = 0; slave_data = 32'h1111_2222;
      send(RGGEN_READ, 8'h08, 32'h0, 4'hF, a1);
      send(RGGEN_READ, 8'h0C, 32'h0, 4'hF, a2);
      check("t3_accept_gap", a2 - a1, 2);
      @(negedge clk);
      check("t3_bus_valid", bus_if.valid, 1'b1);
      check("t3_address", bus_if.address, 8'h0C);
      @(negedge clk);
      check("t3_rsp_valid", rsp_valid, 1'b1);
      check("t3_data", rsp_read_data, 32'h1111_2222);
      @(posedge clk); #1 rsp_ready = 0;
      // response held under backpressure
      slave_wait = 1; slave_status = RGGEN_SLAVE_ERROR; slave_data = 32'hA5A5_0001;
      send(RGGEN_READ, 8'h30, 32'h0, 4'hF, a1);
      wait_rsp(rc);
      for (int i = 0; i < 4; i++) begin
         if (i != 0) @(negedge clk);
         check("t4_rsp_valid", rsp_valid, 1'b1);
         check("t4_status", rsp_status, RGGEN_SLAVE_ERROR);
         check("t4_data", rsp_read_data, 32'hA5A5_0001);
         check("t4_cmd_ready", cmd_ready, 1'b0);
      end
      consume;
      // timeout after three wait cycles, then a late ready
      slave_wait = 1000; slave_status = RGGEN_OKAY; slave_data = 32'h0;
      send(RGGEN_WRITE, 8'h40, 32'h0BAD_F00D, 4'hF, a1);
      repeat (3) @(negedge clk);
      check("t5_timeout_early", timeout, 1'b0);
      @(negedge clk);
      check("t5_timeout_set", timeout, 1'b1);
      check("t5_valid_held", bus_if.valid, 1'b1);
      @(negedge clk);
      check("t5_timeout_stays", timeout, 1'b1);
      slave_wait = 0;
      wait_rsp(rc);
      check("t5_timeout_clear", timeout, 1'b0);
      check("t5_status", rsp_status, RGGEN_OKAY);
      consume;
      // reset while a request is stalled
      slave_wait = 1000;
      send(RGGEN_READ, 8'h50, 32'h0, 4'hF, a1);
      repeat (2) @(negedge clk);
      @(posedge clk); #1 rst_n = 0;
      @(posedge clk); #1 rst_n = 1;
      @(negedge clk);
      check("t6_bus_valid", bus_if.valid, 1'b0);
      check("t6_rsp_valid", rsp_valid, 1'b0);
      check("t6_cmd_ready", cmd_ready, 1'b1);
      repeat (3) @(negedge clk);
      check("t6_no_rsp", rsp_valid, 1'b0);
      slave_wait = 2; slave_data = 32'h600D_600D;
      @(posedge clk); #1;
      send(RGGEN_READ, 8'h54, 32'h0, 4'hF, a1);
      wait_rsp(rc);
      check("t6_recover_data", rsp_read_data, 32'h600D_600D);
      consume;
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
